// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard and forwarding unit for the five-stage RV32I forwarding core.
//   A three-slot scoreboard (EX, MEM, WB) mirrors the back end of the pipe.
//   The scoreboard drives the ID-stage operand forwarding selects, the
//   load-use stall and the redirect flushes.
//
// Ports
//   clk_i          core clock, rising edge
//   rst_n_i        asynchronous active-low reset; forces every output to its idle value
//   id_valid_i     ID holds a real instruction (0 = bubble)
//   id_rs1_i/rs2_i ID source registers
//   id_use_r1_i/r2_i  source operand is actually read
//   id_rd_i, id_we_i, id_is_load_i  destination tag of the ID instruction
//   ex_redirect_i  EX resolved a taken branch / jal / jalr this cycle
//   stall_o        hold PC and IF/ID, bubble into ID/EX
//   flush_ifid_o, flush_idex_o  clear the front pipeline registers
//   fwd_rs1_sel_o/fwd_rs2_sel_o 00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_cnt_o    saturating count of load-use stall cycles since reset
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_r1_i,
  input  logic             id_use_r2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_we_i,
  input  logic             id_is_load_i,
  input  logic             ex_redirect_i,
  output logic             stall_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // A slot produces register r only if it is live, writes, and r is not x0.
  function automatic logic slot_writes(input logic       vld,
                                       input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] r);
    return vld && we && (rd == r) && (r != 5'd0);
  endfunction

  // Nearest-first forwarding. A load sitting in EX has no data yet, so the
  // operand reads the regfile (don't-care) while the stall is in effect.
  function automatic logic [1:0] fwd_sel(input logic use_op,
                                         input logic ex_hit,
                                         input logic ex_ld,
                                         input logic mem_hit,
                                         input logic wb_hit);
    if (!use_op)  return 2'b00;
    if (ex_hit)   return ex_ld ? 2'b00 : 2'b01;
    if (mem_hit)  return 2'b10;
    if (wb_hit)   return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Scoreboard slots: _p0 = EX, _p1 = MEM, _p2 = WB
  logic             ex_vld_p0, ex_we_p0, ex_ld_p0;
  logic [4:0]       ex_rd_p0;
  logic             mem_vld_p1, mem_we_p1;
  logic [4:0]       mem_rd_p1;
  logic             wb_vld_p2, wb_we_p2;
  logic [4:0]       wb_rd_p2;
  logic [CNT_W-1:0] stall_cnt_q;

  logic use1, use2;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic load_use, stall_raw;
  logic [1:0] sel1, sel2;

  // ID stage: combinational hazard decode against the scoreboard
  always_comb begin
    use1      = id_valid_i && id_use_r1_i;
    use2      = id_valid_i && id_use_r2_i;
    ex_hit1   = slot_writes(ex_vld_p0,  ex_we_p0,  ex_rd_p0,  id_rs1_i);
    ex_hit2   = slot_writes(ex_vld_p0,  ex_we_p0,  ex_rd_p0,  id_rs2_i);
    mem_hit1  = slot_writes(mem_vld_p1, mem_we_p1, mem_rd_p1, id_rs1_i);
    mem_hit2  = slot_writes(mem_vld_p1, mem_we_p1, mem_rd_p1, id_rs2_i);
    wb_hit1   = slot_writes(wb_vld_p2,  wb_we_p2,  wb_rd_p2,  id_rs1_i);
    wb_hit2   = slot_writes(wb_vld_p2,  wb_we_p2,  wb_rd_p2,  id_rs2_i);
    load_use  = ex_ld_p0 && ((use1 && ex_hit1) || (use2 && ex_hit2));
    // The redirect kills the ID instruction anyway, so it overrides the stall.
    stall_raw = load_use && !ex_redirect_i;
    sel1      = fwd_sel(use1, ex_hit1, ex_ld_p0, mem_hit1, wb_hit1);
    sel2      = fwd_sel(use2, ex_hit2, ex_ld_p0, mem_hit2, wb_hit2);
  end

  // Outputs are held idle for as long as reset is asserted.
  assign stall_o       = rst_n_i && stall_raw;
  assign flush_ifid_o  = rst_n_i && ex_redirect_i;
  assign flush_idex_o  = rst_n_i && ex_redirect_i;
  assign fwd_rs1_sel_o = rst_n_i ? sel1 : 2'b00;
  assign fwd_rs2_sel_o = rst_n_i ? sel2 : 2'b00;
  assign stall_cnt_o   = stall_cnt_q;

  // ID -> EX -> MEM -> WB: slot valids and stall counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_vld_p0   <= 1'b0;
      mem_vld_p1  <= 1'b0;
      wb_vld_p2   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_vld_p0  <= id_valid_i && !ex_redirect_i && !stall_raw;
      mem_vld_p1 <= ex_vld_p0;
      wb_vld_p2  <= mem_vld_p1;
      if (stall_raw) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // ID -> EX -> MEM -> WB: slot tags, qualified by the valids above
  always_ff @(posedge clk_i) begin
    ex_we_p0  <= id_we_i;
    ex_rd_p0  <= id_rd_i;
    ex_ld_p0  <= id_is_load_i;
    mem_we_p1 <= ex_we_p0;
    mem_rd_p1 <= ex_rd_p0;
    wb_we_p2  <= mem_we_p1;
    wb_rd_p2  <= mem_rd_p1;
  end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  localparam int CNT_W = 16;
  localparam int VW    = 7 + CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use1 = 1'b0, use2 = 1'b0, we = 1'b0, ld = 1'b0, redir = 1'b0;
  logic stall_o, flush_ifid_o, flush_idex_o;
  logic [1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [VW-1:0] act;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_r1_i(use1), .id_use_r2_i(use2),
    .id_rd_i(rd), .id_we_i(we), .id_is_load_i(ld), .ex_redirect_i(redir),
    .stall_o(stall_o), .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
    .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
    .stall_cnt_o(stall_cnt_o)
  );

  assign act = {stall_o, flush_ifid_o, flush_idex_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o};

  // ---------------- reference model: in-flight instruction list ----------------
  typedef struct {
    bit       v;
    bit       we;
    bit [4:0] rd;
    bit       ld;
  } slot_t;

  slot_t pipe[$];          // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  logic [CNT_W-1:0] m_cnt;

  function automatic bit m_writes(slot_t s, logic [4:0] r);
    return s.v && s.we && (s.rd == r) && (r != 0);
  endfunction

  function automatic logic [1:0] m_sel(logic [4:0] rs, logic u);
    if (!(id_valid && u)) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (m_writes(pipe[i], rs)) begin
        if (i == 0 && pipe[i].ld) return 2'd0;
        return 2'(i + 1);
      end
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    if (redir || !id_valid || !pipe[0].ld) return 1'b0;
    return (use1 && m_writes(pipe[0], rs1)) || (use2 && m_writes(pipe[0], rs2));
  endfunction

  function automatic logic [VW-1:0] m_out();
    if (!rst_n) return '0;
    return {m_stall(), redir, redir, m_sel(rs1, use1), m_sel(rs2, use2), m_cnt};
  endfunction

  task automatic m_reset();
    slot_t e;
    e = '{v: 1'b0, we: 1'b0, rd: 5'd0, ld: 1'b0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(e);
    m_cnt = '0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] d,
                        input logic w, input logic l, input logic rdr);
    id_valid = v; rs1 = r1; rs2 = r2; use1 = u1; use2 = u2;
    rd = d; we = w; ld = l; redir = rdr;
  endtask

  // Advance one clock; the model retires WB and admits the ID instruction (or a bubble).
  task automatic tick();
    slot_t n;
    bit st;
    st = m_stall();
    n = '{v: id_valid && !redir && !st, we: we, rd: rd, ld: ld};
    @(posedge clk);
    if (rst_n) begin
      if (st && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic bubbles(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_reset();
    set_id(1, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 1);
    #3;
    n_cmp++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL reset_hold actual=%h required=%h", act, {VW{1'b0}});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL reset_after_edge actual=%h required=%h", act, {VW{1'b0}});
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);   // add x5,x1,x2
    tick();
    set_id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0);   // add x6,x5,x1
    #4;
    n_cmp++;
    if ({stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o} !== {1'b0, 2'b01, 2'b00}) begin
      n_err++;
      $display("FAIL b2b_alu actual=%b required=%b", {stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o}, 5'b0_01_00);
    end
    tick();
  endtask

  task automatic test_distance();
    logic [1:0] exp_sel[5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
    for (int op = 0; op < 2; op++)
      for (int k = 2; k <= 4; k++) begin
        bubbles(3);
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
        tick();
        bubbles(k - 1);
        if (op == 0) set_id(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
        else         set_id(1, 5'd1, 5'd5, 1, 1, 5'd0, 0, 0, 0);
        #4;
        n_cmp++;
        if ((op == 0 ? fwd_rs1_sel_o : fwd_rs2_sel_o) !== exp_sel[k] || stall_o !== 1'b0) begin
          n_err++;
          $display("FAIL distance_rs%0d_k%0d actual=%b stall=%b required=%b", op + 1, k,
                   (op == 0 ? fwd_rs1_sel_o : fwd_rs2_sel_o), stall_o, exp_sel[k]);
        end
        tick();
      end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);   // lw x7,0(x1)
    tick();
    set_id(1, 5'd2, 5'd7, 1, 1, 5'd0, 0, 0, 0);   // sw x7,0(x2)
    #4;
    n_cmp++;
    if ({stall_o, fwd_rs2_sel_o, stall_cnt_o} !== {1'b1, 2'b00, 16'd0}) begin
      n_err++;
      $display("FAIL load_use_stall actual=%b/%b/%0d required=1/00/0", stall_o, fwd_rs2_sel_o, stall_cnt_o);
    end
    tick();   // same sw re-presented
    #4;
    n_cmp++;
    if ({stall_o, fwd_rs2_sel_o, stall_cnt_o} !== {1'b0, 2'b10, 16'd1}) begin
      n_err++;
      $display("FAIL load_use_resume actual=%b/%b/%0d required=0/10/1", stall_o, fwd_rs2_sel_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);   // writer of x0
    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0, 0);
    #4;
    n_cmp++;
    if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL x0_reader actual=%b required=0000", {fwd_rs1_sel_o, fwd_rs2_sel_o});
    end
    tick();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0);   // writer of x9
    tick();
    set_id(1, 5'd9, 5'd9, 1, 0, 5'd4, 1, 0, 0);   // I-type: rs2 field matches but unused
    #4;
    n_cmp++;
    if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0100) begin
      n_err++;
      $display("FAIL unused_rs2 actual=%b required=0100", {fwd_rs1_sel_o, fwd_rs2_sel_o});
    end
    tick();
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);   // lw x7
    tick();
    set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 1);   // reader of x7, redirect same cycle
    #4;
    n_cmp++;
    if ({flush_ifid_o, flush_idex_o, stall_o} !== 3'b110) begin
      n_err++;
      $display("FAIL redirect_flush actual=%b required=110", {flush_ifid_o, flush_idex_o, stall_o});
    end
    tick();
    set_id(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 0);
    #4;
    n_cmp++;
    if ({fwd_rs1_sel_o, stall_o, stall_cnt_o} !== {2'b10, 1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL redirect_next actual=%b/%b/%0d required=10/0/0", fwd_rs1_sel_o, stall_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);   // lw x7
    tick();
    set_id(1, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 0);   // stalls once
    tick();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0);   // lw x8
    tick();
    set_id(1, 5'd8, 5'd8, 1, 1, 5'd0, 0, 0, 0);   // stalling reader
    #2;
    n_cmp++;
    if ({stall_o, stall_cnt_o} !== {1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL pre_reset_stall actual=%b/%0d required=1/1", stall_o, stall_cnt_o);
    end
    rst_n = 1'b0;
    #1;
    redir = 1'b1;
    #1;
    n_cmp++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL async_reset actual=%h required=%h", act, {VW{1'b0}});
    end
    #1;
    rst_n = 1'b1;
    redir = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL post_release actual=%b/%b/%b/%0d required=0/00/00/0",
               stall_o, fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [VW-1:0] exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      #4;
      exp = m_out();
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL random_%0d actual=%h required=%h", i, act, exp);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_x0_unused();
    test_redirect_load_use();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
